// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Build option: define FETCH_CNT_EN to add a saturating fetch_count output.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               halted
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic [0:0] {RUN, HALTED} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc_p0, pc_nxt;
  logic               vld_p1, vld_nxt;
  logic [INSTR_W-1:0] instr_p1, instr_nxt;
  logic [ADDR_W-1:0]  pc_p1, pc_p1_nxt;
  logic               fetch_adv;
  logic               is_halt;

  assign is_halt   = (imem_instr[INSTR_W-1 -: 4] == HALT_OP);
  assign imem_addr = pc_p0;
  assign halted    = (state == HALTED);

  // Next-state: redirect beats stall beats normal advance
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    vld_nxt   = vld_p1;
    instr_nxt = instr_p1;
    pc_p1_nxt = pc_p1;
    fetch_adv = 1'b0;
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      vld_nxt   = 1'b0;
      state_nxt = RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          fetch_adv = 1'b1;
          instr_nxt = imem_instr;
          pc_p1_nxt = pc_p0;
          vld_nxt   = 1'b1;
          if (is_halt) state_nxt = HALTED;
          else         pc_nxt    = pc_p0 + ADDR_W'(1);
        end
        HALTED: vld_nxt = 1'b0;
        default: state_nxt = RUN;
      endcase
    end
  end

  // p0 -> p1: PC register and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_nxt;
      vld_p1   <= vld_nxt;
      instr_p1 <= instr_nxt;
      pc_p1    <= pc_p1_nxt;
    end
  end

  assign ifid_valid = vld_p1;
  assign ifid_instr = instr_p1;
  assign ifid_pc    = pc_p1;

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      fetch_count <= '0;
    else if (fetch_adv && (fetch_count != 16'hFFFF))
      fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a cycle-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        halted;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  logic [15:0] rom [256];
  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .halted(halted)
`ifdef FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (what fetch should look like after each edge)
  logic [7:0]  m_pc, m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid, m_halted;
  int          m_cnt;

  // Drive one cycle of inputs, advance the model by the fetch rules, then sample after the edge
  task automatic cyc(input logic r, input logic s, input logic rv, input logic [7:0] rp);
    logic [15:0] w;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    if (r) begin
      m_pc = 8'h00; m_valid = 1'b0; m_instr = 16'h0; m_ifpc = 8'h00; m_halted = 1'b0; m_cnt = 0;
    end else if (rv) begin
      m_pc = rp; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!s) begin
      if (!m_halted) begin
        w = rom[m_pc];
        m_instr = w; m_ifpc = m_pc; m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (w[15:12] == 4'hF) m_halted = 1'b1;
        else m_pc = m_pc + 8'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
    rom[0] = 16'h4100; rom[1] = 16'h4202; rom[2] = 16'h0321; rom[5] = 16'hF000;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h77);
    n_cmp++;
    if ({imem_addr, ifid_valid, ifid_instr, ifid_pc, halted} !== {8'h00, 1'b0, 16'h0000, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got addr=%h v=%b instr=%h pc=%h halted=%b exp 00/0/0000/00/0",
               imem_addr, ifid_valid, ifid_instr, ifid_pc, halted);
    end
`ifdef FETCH_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count);
    end
`endif
  endtask

  task automatic test_sequential();
    logic [15:0] exp_i [3];
    exp_i[0] = 16'h4100; exp_i[1] = 16'h4202; exp_i[2] = 16'h0321;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 8'h00);
      n_cmp++;
      if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, exp_i[k], 8'(k)}) begin
        n_fail++;
        $display("FAIL seq_fetch%0d got v=%b instr=%h pc=%h exp 1/%h/%h",
                 k, ifid_valid, ifid_instr, ifid_pc, exp_i[k], 8'(k));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 8'h00);
      n_cmp++;
      if ({imem_addr, ifid_valid, ifid_instr, ifid_pc} !== {8'h02, 1'b1, 16'h4202, 8'h01}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got addr=%h v=%b instr=%h pc=%h exp 02/1/4202/01",
                 k, imem_addr, ifid_valid, ifid_instr, ifid_pc);
      end
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc, imem_addr} !== {1'b1, 16'h0321, 8'h02, 8'h03}) begin
      n_fail++;
      $display("FAIL stall_release got v=%b instr=%h pc=%h addr=%h exp 1/0321/02/03",
               ifid_valid, ifid_instr, ifid_pc, imem_addr);
    end
  endtask

  task automatic test_redirect();
    cyc(0, 1, 1, 8'h10);
    n_cmp++;
    if ({ifid_valid, imem_addr} !== {1'b0, 8'h10}) begin
      n_fail++;
      $display("FAIL redirect_flush got v=%b addr=%h exp 0/10", ifid_valid, imem_addr);
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 8'h10, rom[8'h10]}) begin
      n_fail++;
      $display("FAIL redirect_target got v=%b pc=%h instr=%h exp 1/10/%h",
               ifid_valid, ifid_pc, ifid_instr, rom[8'h10]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    cyc(0, 0, 1, 8'hFE);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 8'h00);
      n_cmp++;
      if ({ifid_valid, ifid_pc} !== {1'b1, exp_pc[k]}) begin
        n_fail++;
        $display("FAIL wrap_pc%0d got v=%b pc=%h exp 1/%h", k, ifid_valid, ifid_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_halt();
    cyc(0, 0, 1, 8'h03);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc, halted, imem_addr} !== {1'b1, 16'hF000, 8'h05, 1'b1, 8'h05}) begin
      n_fail++;
      $display("FAIL halt_capture got v=%b instr=%h pc=%h halted=%b addr=%h exp 1/F000/05/1/05",
               ifid_valid, ifid_instr, ifid_pc, halted, imem_addr);
    end
    cyc(0, 1, 0, 8'h00);
    n_cmp++;
    if ({ifid_valid, ifid_instr, halted} !== {1'b1, 16'hF000, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_stall_hold got v=%b instr=%h halted=%b exp 1/F000/1", ifid_valid, ifid_instr, halted);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 8'h00);
      n_cmp++;
      if ({ifid_valid, halted, imem_addr} !== {1'b0, 1'b1, 8'h05}) begin
        n_fail++;
        $display("FAIL halt_frozen%0d got v=%b halted=%b addr=%h exp 0/1/05", k, ifid_valid, halted, imem_addr);
      end
    end
    cyc(0, 0, 1, 8'h00);
    n_cmp++;
    if ({halted, ifid_valid, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL halt_redirect got halted=%b v=%b addr=%h exp 0/0/00", halted, ifid_valid, imem_addr);
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 8'h00, 16'h4100}) begin
      n_fail++;
      $display("FAIL halt_resume got v=%b pc=%h instr=%h exp 1/00/4100", ifid_valid, ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_reset_mid_halt();
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if ({halted, ifid_instr} !== {1'b1, 16'hF000}) begin
      n_fail++; $display("FAIL rmh_halted got halted=%b instr=%h exp 1/F000", halted, ifid_instr);
    end
`ifdef FETCH_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd6) begin
      n_fail++; $display("FAIL rmh_count6 got=%0d exp=6", fetch_count);
    end
`endif
    cyc(0, 0, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    n_cmp++;
    if ({imem_addr, halted, ifid_valid} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rmh_reset got addr=%h halted=%b v=%b exp 00/0/0", imem_addr, halted, ifid_valid);
    end
`ifdef FETCH_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL rmh_count0 got=%0d exp=0", fetch_count);
    end
`endif
  endtask

  task automatic test_random();
    logic r, s, rv;
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      rv = ($urandom_range(0, 99) < 10);
      cyc(r, s, rv, 8'($urandom));
      n_cmp++;
      if ({imem_addr, ifid_valid, halted} !== {m_pc, m_valid, m_halted}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc%0d got addr=%h v=%b halted=%b exp %h/%b/%b",
                 k, imem_addr, ifid_valid, halted, m_pc, m_valid, m_halted);
      end
      if (m_valid) begin
        n_cmp++;
        if ({ifid_instr, ifid_pc} !== {m_instr, m_ifpc}) begin
          n_fail++;
          $display("FAIL rand_data cyc%0d got instr=%h pc=%h exp %h/%h", k, ifid_instr, ifid_pc, m_instr, m_ifpc);
        end
      end
`ifdef FETCH_CNT_EN
      n_cmp++;
      if (fetch_count !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_count cyc%0d got=%0d exp=%0d", k, fetch_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    init_rom();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
